// File: rtl/or_fifo_regif.sv
// ----------------------------------------------------------------------------
// or_fifo_regif
//   Register-mapped 1-bit OR engine. The host pushes operand bits into FIFO A
//   and FIFO B via the write port. Whenever both operand FIFOs hold data and
//   the result FIFO has room (all judged at cycle start), one operand pair is
//   consumed and A|B is queued in FIFO Y. Status and results are read back
//   through the read port.
//
// Ports:
//   CLK            in   clock, rising edge
//   RST_N          in   asynchronous active-low reset
//   write_address  in   [2:0] write register select (4 -> A, 5 -> B)
//   write_data     in   operand bit
//   write_en       in   write strobe
//   write_rdy      out  write port ready (high whenever out of reset)
//   read_address   in   [2:0] read register select
//   read_en        in   read strobe (pop Y at address 3)
//   read_data      out  combinational read data
//   read_rdy       out  read port ready (high whenever out of reset)
//
// Read map: 0 A not full, 1 B not full, 2 Y not empty, 3 head of Y (0 if
// empty), 6 overflow flag, 7 underflow flag, others 0.
//
// Optional feature macro: OR_FIFO_ERR_FLAGS_EN
//   Defined   -> sticky overflow (addr 6) / underflow (addr 7) flags, cleared
//                by a read_en at their address; a set event wins over clear.
//   Undefined -> addresses 6 and 7 read 0 and no flag logic is built.
// ----------------------------------------------------------------------------

// Small 1-bit-wide FIFO. A push into a FIFO that is full at cycle start is
// dropped even if a pop happens in the same cycle.
module or_fifo_regif_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q,    mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PW'(DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = ptr + PW'(1);
    end
    return nxt;
  endfunction

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

module or_fifo_regif #(
  parameter int unsigned A_DEPTH = 2,
  parameter int unsigned B_DEPTH = 1,
  parameter int unsigned Y_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] write_address,
  input  logic       write_data,
  input  logic       write_en,
  output logic       write_rdy,
  input  logic [2:0] read_address,
  input  logic       read_en,
  output logic       read_data,
  output logic       read_rdy
);

  logic a_full_s,  a_empty_s, a_head_s;
  logic b_full_s,  b_empty_s, b_head_s;
  logic y_full_s,  y_empty_s, y_head_s;
  logic wr_ok_s,   rd_ok_s;
  logic push_a_req_s, push_b_req_s;
  logic xfer_s;
  logic y_pop_s;
  logic rd_mux_s;

  // The ports are ready exactly when the block is out of reset.
  assign write_rdy = RST_N;
  assign read_rdy  = RST_N;
  assign wr_ok_s   = write_en & RST_N;
  assign rd_ok_s   = read_en & RST_N;

  assign push_a_req_s = wr_ok_s & (write_address == 3'd4);
  assign push_b_req_s = wr_ok_s & (write_address == 3'd5);

  // One transfer per cycle, judged on the occupancy at cycle start; a host
  // pop of Y in the same cycle does not make room for it.
  assign xfer_s  = ~a_empty_s & ~b_empty_s & ~y_full_s;
  assign y_pop_s = rd_ok_s & (read_address == 3'd3) & ~y_empty_s;

  or_fifo_regif_fifo #(.DEPTH(A_DEPTH)) u_fifo_a (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push_a_req_s),
    .data_i  (write_data),
    .pop_i   (xfer_s),
    .full_o  (a_full_s),
    .empty_o (a_empty_s),
    .head_o  (a_head_s)
  );

  or_fifo_regif_fifo #(.DEPTH(B_DEPTH)) u_fifo_b (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push_b_req_s),
    .data_i  (write_data),
    .pop_i   (xfer_s),
    .full_o  (b_full_s),
    .empty_o (b_empty_s),
    .head_o  (b_head_s)
  );

  or_fifo_regif_fifo #(.DEPTH(Y_DEPTH)) u_fifo_y (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (xfer_s),
    .data_i  (a_head_s | b_head_s),
    .pop_i   (y_pop_s),
    .full_o  (y_full_s),
    .empty_o (y_empty_s),
    .head_o  (y_head_s)
  );

`ifdef OR_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_set_s, udf_set_s;

  assign ovf_set_s = (push_a_req_s & a_full_s) | (push_b_req_s & b_full_s);
  assign udf_set_s = rd_ok_s & (read_address == 3'd3) & y_empty_s;

  // Sticky error flags: a set event in the same cycle beats a clearing read.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (rd_ok_s && (read_address == 3'd6)) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (udf_set_s) begin
      udf_d = 1'b1;
    end else if (rd_ok_s && (read_address == 3'd7)) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
`endif

  // Read data mux; status reads have no side effects.
  always_comb begin
    rd_mux_s = 1'b0;
    case (read_address)
      3'd0: rd_mux_s = ~a_full_s;
      3'd1: rd_mux_s = ~b_full_s;
      3'd2: rd_mux_s = ~y_empty_s;
      3'd3: begin
        if (y_empty_s) begin
          rd_mux_s = 1'b0;
        end else begin
          rd_mux_s = y_head_s;
        end
      end
`ifdef OR_FIFO_ERR_FLAGS_EN
      3'd6: rd_mux_s = ovf_q;
      3'd7: rd_mux_s = udf_q;
`endif
      default: rd_mux_s = 1'b0;
    endcase
  end

  // Read data is forced low while reset is asserted.
  assign read_data = RST_N & rd_mux_s;

endmodule

// File: tb/tb_or_fifo_regif.sv
// ----------------------------------------------------------------------------
// tb_or_fifo_regif
//   Directed bench for or_fifo_regif. A queue-based model of the three FIFOs
//   is advanced on every rising edge; on every falling edge all eight read
//   addresses are swept and compared with the model, together with the ready
//   outputs. Hand-computed literal expectations pin the model at key points.
// ----------------------------------------------------------------------------
module tb_or_fifo_regif;

  localparam int A_D = 2;
  localparam int B_D = 1;
  localparam int Y_D = 2;

  logic       CLK;
  logic       RST_N;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] stim_raddr;
  logic [2:0] sweep_addr;
  logic       sweep_on;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  bit qa[$];
  bit qb[$];
  bit qy[$];
`ifdef OR_FIFO_ERR_FLAGS_EN
  bit m_ovf;
  bit m_udf;
`endif
  int n_checks;
  int n_fail;

  assign read_address = sweep_on ? sweep_addr : stim_raddr;

  or_fifo_regif dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  function automatic bit model_read(input logic [2:0] a);
    bit r;
    r = 1'b0;
    if (RST_N !== 1'b1) return 1'b0;
    case (a)
      3'd0: r = (qa.size() < A_D);
      3'd1: r = (qb.size() < B_D);
      3'd2: r = (qy.size() != 0);
      3'd3: r = (qy.size() != 0) ? qy[0] : 1'b0;
`ifdef OR_FIFO_ERR_FLAGS_EN
      3'd6: r = m_ovf;
      3'd7: r = m_udf;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    qy.delete();
`ifdef OR_FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0;
    m_udf = 1'b0;
`endif
  endtask

  // Apply the block's rules to the inputs present at this rising edge.
  task automatic model_edge();
    bit a_full, b_full, y_empty, xfer, ypop, ha, hb, wa, wb;
    if (RST_N !== 1'b1) begin
      model_clear();
      return;
    end
    a_full  = (qa.size() == A_D);
    b_full  = (qb.size() == B_D);
    y_empty = (qy.size() == 0);
    xfer    = (qa.size() > 0) && (qb.size() > 0) && (qy.size() < Y_D);
    ypop    = read_en && (stim_raddr == 3'd3) && !y_empty;
    wa      = write_en && (write_address == 3'd4);
    wb      = write_en && (write_address == 3'd5);
`ifdef OR_FIFO_ERR_FLAGS_EN
    if ((wa && a_full) || (wb && b_full)) m_ovf = 1'b1;
    else if (read_en && stim_raddr == 3'd6) m_ovf = 1'b0;
    if (read_en && stim_raddr == 3'd3 && y_empty) m_udf = 1'b1;
    else if (read_en && stim_raddr == 3'd7) m_udf = 1'b0;
`endif
    if (ypop) void'(qy.pop_front());
    if (xfer) begin
      ha = qa.pop_front();
      hb = qb.pop_front();
      qy.push_back(ha | hb);
    end
    if (wa && !a_full) qa.push_back(write_data);
    if (wb && !b_full) qb.push_back(write_data);
  endtask

  // One clock: sweep-compare at the falling edge, model update at the rising.
  task automatic tick();
    @(negedge CLK);
    for (int a = 0; a < 8; a++) begin
      sweep_addr = 3'(a);
      sweep_on   = 1'b1;
      #1;
      check($sformatf("sweep_addr%0d", a), read_data, model_read(3'(a)));
    end
    sweep_on = 1'b0;
    check("write_rdy", write_rdy, RST_N);
    check("read_rdy", read_rdy, RST_N);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic d);
    write_address = a;
    write_data    = d;
    write_en      = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    stim_raddr = a;
    read_en    = 1'b1;
    tick();
    read_en = 1'b0;
  endtask

  task automatic lit(input logic [2:0] a, input logic exp, input string name);
    stim_raddr = a;
    #1;
    check(name, read_data, exp);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    model_clear();
    #1;
    check("rst_read_data", read_data, 1'b0);
    check("rst_write_rdy", write_rdy, 1'b0);
    check("rst_read_rdy", read_rdy, 1'b0);
    idle(2);
    RST_N = 1'b1;
  endtask

  bit ta[4];
  bit tbv[4];
  bit te[4];

  initial begin
    n_checks = 0;
    n_fail = 0;
    RST_N = 1'b0;
    write_address = 3'd0;
    write_data = 1'b0;
    write_en = 1'b0;
    stim_raddr = 3'd0;
    sweep_addr = 3'd0;
    sweep_on = 1'b0;
    read_en = 1'b0;
    ta  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbv = '{1'b0, 1'b1, 1'b0, 1'b1};
    te  = '{1'b0, 1'b1, 1'b1, 1'b1};
    model_clear();
    #3;
    do_reset();

    // Reset state.
    lit(3'd0, 1'b1, "reset_a_not_full");
    lit(3'd1, 1'b1, "reset_b_not_full");
    lit(3'd2, 1'b0, "reset_y_not_empty");
    lit(3'd3, 1'b0, "reset_y_head");
    check("reset_write_rdy", write_rdy, 1'b1);
    check("reset_read_rdy", read_rdy, 1'b1);

    // Single OR with latency.
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b0);
    lit(3'd2, 1'b0, "single_not_yet");
    idle(1);
    lit(3'd2, 1'b1, "single_y_status");
    lit(3'd3, 1'b1, "single_result");
    rd(3'd3);
    lit(3'd2, 1'b0, "single_popped");

    // Truth table.
    for (int i = 0; i < 4; i++) begin
      wr(3'd4, ta[i]);
      wr(3'd5, tbv[i]);
      idle(1);
      lit(3'd2, 1'b1, $sformatf("tt%0d_status", i));
      lit(3'd3, te[i], $sformatf("tt%0d_result", i));
      rd(3'd3);
    end

    // Full flags and dropped write.
    wr(3'd4, 1'b1);
    wr(3'd4, 1'b0);
    lit(3'd0, 1'b0, "a_full");
    wr(3'd4, 1'b1);
    lit(3'd0, 1'b0, "a_full_after_drop");
    wr(3'd5, 1'b0);
    lit(3'd1, 1'b0, "b_full");
    idle(1);
    lit(3'd1, 1'b1, "b_drained");
    wr(3'd5, 1'b0);
    idle(1);
    lit(3'd3, 1'b1, "drop_res0");
    rd(3'd3);
    lit(3'd3, 1'b0, "drop_res1");
    rd(3'd3);
    lit(3'd2, 1'b0, "drop_y_empty");
    lit(3'd0, 1'b1, "drop_a_empty");
    wr(3'd5, 1'b0);
    idle(1);
    lit(3'd2, 1'b0, "drop_no_leftover");
    wr(3'd4, 1'b1);
    idle(1);
    lit(3'd3, 1'b1, "drop_cleanup");
    rd(3'd3);

    // Y backpressure: pairs (1,0),(0,0),(0,1),(1,1); last B is dropped.
    wr(3'd4, 1'b1); wr(3'd5, 1'b0);
    wr(3'd4, 1'b0); wr(3'd5, 1'b0);
    wr(3'd4, 1'b0); wr(3'd5, 1'b1);
    wr(3'd4, 1'b1); wr(3'd5, 1'b1);
    lit(3'd2, 1'b1, "bp_y_status");
    lit(3'd0, 1'b0, "bp_a_full");
    lit(3'd1, 1'b0, "bp_b_full");
    lit(3'd3, 1'b1, "bp_res0");
    rd(3'd3);
    idle(1);
    lit(3'd3, 1'b0, "bp_res1");
    rd(3'd3);
    idle(1);
    wr(3'd5, 1'b1);
    idle(1);
    lit(3'd3, 1'b1, "bp_res2");
    rd(3'd3);
    lit(3'd3, 1'b1, "bp_res3");
    rd(3'd3);
    lit(3'd2, 1'b0, "bp_drained");

    // Transfer push and host pop of Y in the same cycle.
    wr(3'd4, 1'b1); wr(3'd5, 1'b0);
    idle(1);
    wr(3'd4, 1'b0); wr(3'd5, 1'b0);
    rd(3'd3);
    lit(3'd2, 1'b1, "same_cycle_status");
    lit(3'd3, 1'b0, "same_cycle_result");
    rd(3'd3);
    lit(3'd2, 1'b0, "same_cycle_empty");

    // Empty read.
    lit(3'd3, 1'b0, "empty_head");
    rd(3'd3);
    lit(3'd2, 1'b0, "empty_after_read");
    lit(3'd0, 1'b1, "empty_a_ok");
`ifdef OR_FIFO_ERR_FLAGS_EN
    lit(3'd7, 1'b1, "udf_set");
    lit(3'd6, 1'b1, "ovf_set");
    rd(3'd7);
    rd(3'd6);
    lit(3'd7, 1'b0, "udf_cleared");
    lit(3'd6, 1'b0, "ovf_cleared");
`endif

    // Reset mid-operation.
    wr(3'd4, 1'b1);
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b1);
    do_reset();
    lit(3'd0, 1'b1, "midrst_a");
    lit(3'd1, 1'b1, "midrst_b");
    lit(3'd2, 1'b0, "midrst_y");
    idle(2);
    lit(3'd2, 1'b0, "midrst_no_xfer");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
